// File: rtl/bcd_timer_controller.sv
// Start/stop/lap BCD timer: run/pause/done FSM, tick prescaler,
// decade carry chain, terminal compare and lap capture.
module bcd_timer_controller #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 1
) (
    input  logic                  Clk,
    input  logic                  Clr,
    input  logic                  Start,
    input  logic                  Stop,
    input  logic                  Lap,
    input  logic [4*DIGITS-1:0]   Limit,
    output logic [4*DIGITS-1:0]   Q,
    output logic [4*DIGITS-1:0]   LapQ,
    output logic                  Running,
    output logic                  Done,
    output logic [1:0]            State
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [W-1:0]  r_q;
    logic [W-1:0]  w_q_nx;
    logic [W-1:0]  w_q_inc;
    logic [W-1:0]  r_lapq;
    logic [PW-1:0] r_pre;
    logic [PW-1:0] w_pre_nx;
    logic [DIGITS:0] w_all9;
    logic          w_tick;
    logic          w_lim0;

    // Digit i steps only when every lower digit sits at 9.
    assign w_all9[0] = 1'b1;
    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        logic [3:0] w_d;
        assign w_d = r_q[4*i +: 4];
        assign w_all9[i+1] = w_all9[i] & (w_d == 4'd9);
        assign w_q_inc[4*i +: 4] = !w_all9[i]    ? w_d  :
                                   (w_d == 4'd9) ? 4'd0 :
                                   w_d + 4'd1;
    end

    assign w_tick = (r_state == S_RUN) && !Stop && (r_pre == PMAX);
    assign w_lim0 = (Limit == '0);

    always_comb begin
        w_state_nx = r_state;
        w_q_nx     = r_q;
        w_pre_nx   = r_pre;
        unique case (r_state)
            S_IDLE: begin
                w_q_nx = '0;
                if (Start && !Stop) begin
                    w_pre_nx   = '0;
                    w_state_nx = w_lim0 ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                // Prescaler keeps its phase through a pause.
                w_pre_nx = (r_pre == PMAX) ? '0 : r_pre + PW'(1);
                if (Stop) begin
                    w_state_nx = S_PAUSE;
                end else if (w_tick) begin
                    w_q_nx = w_q_inc;
                    if (w_q_inc == Limit) begin
                        w_state_nx = S_DONE;
                    end
                end
            end
            S_PAUSE: begin
                if (Stop) begin
                    w_state_nx = S_IDLE;
                    w_q_nx     = '0;
                    w_pre_nx   = '0;
                end else if (Start) begin
                    w_state_nx = S_RUN;
                end
            end
            S_DONE: begin
                if (Stop) begin
                    w_state_nx = S_IDLE;
                    w_q_nx     = '0;
                    w_pre_nx   = '0;
                end else if (Start) begin
                    w_q_nx     = '0;
                    w_pre_nx   = '0;
                    w_state_nx = w_lim0 ? S_DONE : S_RUN;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_lapq  <= '0;
            r_pre   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_q     <= w_q_nx;
            r_pre   <= w_pre_nx;
            if (Lap) begin
                r_lapq <= r_q;
            end
        end
    end

    assign Q       = r_q;
    assign LapQ    = r_lapq;
    assign State   = r_state;
    assign Running = (r_state == S_RUN);
    assign Done    = (r_state == S_DONE);

endmodule

// File: tb/tb_bcd_timer_controller.sv
// Scoreboard bench for bcd_timer_controller: two instances,
// TICK_DIV=1 (a_*) and TICK_DIV=3 (b_*), both DIGITS=2.
module tb_bcd_timer_controller;

    localparam logic [1:0] ID = 2'b00;
    localparam logic [1:0] RN = 2'b01;
    localparam logic [1:0] PS = 2'b10;
    localparam logic [1:0] DN = 2'b11;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       a_clr, a_start, a_stop, a_lap;
    logic [7:0] a_lim, a_q, a_lapq;
    logic       a_run, a_done;
    logic [1:0] a_st;
    logic       b_clr, b_start, b_stop, b_lap;
    logic [7:0] b_lim, b_q, b_lapq;
    logic       b_run, b_done;
    logic [1:0] b_st;

    bcd_timer_controller #(.DIGITS(2), .TICK_DIV(1)) u_a (
        .Clk(Clk), .Clr(a_clr), .Start(a_start), .Stop(a_stop),
        .Lap(a_lap), .Limit(a_lim), .Q(a_q), .LapQ(a_lapq),
        .Running(a_run), .Done(a_done), .State(a_st)
    );

    bcd_timer_controller #(.DIGITS(2), .TICK_DIV(3)) u_b (
        .Clk(Clk), .Clr(b_clr), .Start(b_start), .Stop(b_stop),
        .Lap(b_lap), .Limit(b_lim), .Q(b_q), .LapQ(b_lapq),
        .Running(b_run), .Done(b_done), .State(b_st)
    );

    typedef struct {
        string      nm;
        bit         dut;
        logic [7:0] q;
        logic [7:0] lq;
        logic [1:0] st;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    function automatic logic [7:0] bcd(int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_exp(string nm, bit dut, logic [7:0] q,
                            logic [7:0] lq, logic [1:0] st);
        exp_t e;
        e.nm  = nm;
        e.dut = dut;
        e.q   = q;
        e.lq  = lq;
        e.st  = st;
        sb.push_back(e);
    endtask

    // Monitor: compare every queued expectation against the outputs.
    always @(negedge Clk) begin : mon
        exp_t       e;
        logic [7:0] aq, al;
        logic [1:0] as;
        logic       ar, ad;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.dut) begin
                aq = b_q; al = b_lapq; as = b_st; ar = b_run; ad = b_done;
            end else begin
                aq = a_q; al = a_lapq; as = a_st; ar = a_run; ad = a_done;
            end
            total++;
            if (aq !== e.q || al !== e.lq || as !== e.st ||
                ar !== (e.st == RN) || ad !== (e.st == DN)) begin
                bad++;
                $display("FAIL %s dut%0d: got q=%h lap=%h st=%b run=%b done=%b want q=%h lap=%h st=%b",
                         e.nm, e.dut, aq, al, as, ar, ad, e.q, e.lq, e.st);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        a_clr = 1; a_start = 0; a_stop = 0; a_lap = 0; a_lim = 8'h25;
        b_clr = 1; b_start = 0; b_stop = 0; b_lap = 0; b_lim = 8'hAA;
        cyc();
        push_exp("rst_a", 0, 8'h00, 8'h00, ID);
        push_exp("rst_b", 1, 8'h00, 8'h00, ID);
        a_clr = 0; b_clr = 0;

        // Count to 0x25 with TICK_DIV=1, hold in DONE
        a_start = 1; cyc(); a_start = 0;
        push_exp("start_a", 0, 8'h00, 8'h00, RN);
        for (int n = 1; n <= 30; n++) begin
            cyc();
            push_exp("cnt_a", 0, (n < 25) ? bcd(n) : 8'h25, 8'h00,
                     (n < 25) ? RN : DN);
        end

        a_start = 1; cyc(); a_start = 0;
        push_exp("restart", 0, 8'h00, 8'h00, RN);
        cyc();
        push_exp("restart_inc", 0, 8'h01, 8'h00, RN);
        a_stop = 1; cyc();
        push_exp("stop_run", 0, 8'h01, 8'h00, PS);
        cyc(); a_stop = 0;
        push_exp("stop_pause", 0, 8'h00, 8'h00, ID);

        // Start and Stop together
        a_start = 1; a_stop = 1; cyc();
        push_exp("ss_idle", 0, 8'h00, 8'h00, ID);
        a_stop = 0; cyc(); a_start = 0;
        push_exp("start2", 0, 8'h00, 8'h00, RN);
        cyc();
        push_exp("inc2", 0, 8'h01, 8'h00, RN);
        a_start = 1; a_stop = 1; cyc(); a_start = 0; a_stop = 0;
        push_exp("ss_run", 0, 8'h01, 8'h00, PS);
        cyc();
        push_exp("pause_hold", 0, 8'h01, 8'h00, PS);
        a_stop = 1; cyc(); a_stop = 0;
        push_exp("stop2", 0, 8'h00, 8'h00, ID);

        // Lap across the 0x19 -> 0x20 carry, then Clr with Lap high
        a_start = 1; cyc(); a_start = 0;
        push_exp("start3", 0, 8'h00, 8'h00, RN);
        for (int n = 1; n <= 19; n++) begin
            cyc();
            push_exp("lapcnt", 0, bcd(n), 8'h00, RN);
        end
        a_lap = 1; cyc();
        push_exp("lap", 0, 8'h20, 8'h19, RN);
        a_clr = 1; cyc(); a_clr = 0; a_lap = 0;
        push_exp("clr_lap", 0, 8'h00, 8'h00, ID);
        a_start = 1; cyc(); a_start = 0;
        push_exp("post_clr", 0, 8'h00, 8'h00, RN);
        cyc();
        push_exp("post_clr_inc", 0, 8'h01, 8'h00, RN);

        // Limit = 0 goes straight to DONE
        a_stop = 1; cyc();
        push_exp("stop3", 0, 8'h01, 8'h00, PS);
        cyc(); a_stop = 0;
        push_exp("stop4", 0, 8'h00, 8'h00, ID);
        a_lim = 8'h00; a_start = 1; cyc();
        push_exp("lim0", 0, 8'h00, 8'h00, DN);
        cyc(); a_start = 0;
        push_exp("lim0_restart", 0, 8'h00, 8'h00, DN);
        a_stop = 1; cyc(); a_stop = 0;
        push_exp("done_stop", 0, 8'h00, 8'h00, ID);

        // TICK_DIV=3, invalid limit: full wrap, never DONE
        b_start = 1; cyc(); b_start = 0;
        push_exp("start_b", 1, 8'h00, 8'h00, RN);
        for (int k = 1; k <= 300; k++) begin
            cyc();
            push_exp("wrap_b", 1, bcd((k / 3) % 100), 8'h00, RN);
        end
        b_stop = 1; cyc();
        push_exp("stop_b", 1, 8'h00, 8'h00, PS);
        cyc(); b_stop = 0;
        push_exp("idle_b", 1, 8'h00, 8'h00, ID);

        // Prescaler phase preserved across pause
        b_start = 1; cyc(); b_start = 0;
        push_exp("start_b2", 1, 8'h00, 8'h00, RN);
        cyc(); push_exp("ph1", 1, 8'h00, 8'h00, RN);
        cyc(); push_exp("ph2", 1, 8'h00, 8'h00, RN);
        cyc(); push_exp("ph3", 1, 8'h01, 8'h00, RN);
        b_stop = 1; cyc(); b_stop = 0;
        push_exp("pause_b", 1, 8'h01, 8'h00, PS);
        for (int k = 0; k < 10; k++) begin
            cyc();
            push_exp("pause_hold_b", 1, 8'h01, 8'h00, PS);
        end
        b_start = 1; cyc(); b_start = 0;
        push_exp("resume", 1, 8'h01, 8'h00, RN);
        cyc(); push_exp("resume+1", 1, 8'h01, 8'h00, RN);
        cyc(); push_exp("resume+2", 1, 8'h02, 8'h00, RN);
        cyc(); push_exp("resume+3", 1, 8'h02, 8'h00, RN);
        cyc(); push_exp("resume+4", 1, 8'h02, 8'h00, RN);
        cyc(); push_exp("resume+5", 1, 8'h03, 8'h00, RN);

        @(negedge Clk);
        #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
